// File: rtl/fetch_predict_unit.sv
// fetch_predict_unit
//
// Fetch-stage next-PC generator that feeds the gshare branch predictor. It
// drives the fetch address, and the predictor returns a combinational taken
// bit for that address. A direct-mapped BTB supplies taken-branch targets.
// Every fetched instruction is tracked through decode (F/D) to the ALU slot
// (D/A), where the real outcome is compared against what was predicted.
// On a misprediction, fetch is redirected, younger entries are flushed and the
// BTB is trained.
//
// Ports:
//   i_Clk, i_Reset          clock and asynchronous active-high reset
//   i_Stall                 holds PC and in-flight entries (a redirect wins)
//   i_taken                 predictor direction for the current fetch PC
//   i_ALU_is_branch/_taken  actual nature and outcome of the ALU-slot instr
//   i_ALU_target            actual taken target of the ALU-slot instr
//   o_IMEM_address          current fetch PC
//   o_pred_pc               low PC bits sent to the predictor
//   o_fetch_valid           fetch PC is a real instruction, not a bubble
//   o_isbranch_check        valid BTB hit on a real fetch
//   o_ALU_pc/_isbranch/_prediction  recorded data for the ALU-slot entry
//   o_redirect              misprediction resolved this cycle
//   o_mispredict_count      saturating count of redirects
module fetch_predict_unit #(
    parameter int unsigned ADDRESS_WIDTH  = 22,
    parameter int unsigned GHR_SIZE       = 8,
    parameter int unsigned BTB_INDEX_BITS = 4,
    parameter int unsigned RESET_PC       = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    input  logic                     i_taken,
    input  logic                     i_ALU_is_branch,
    input  logic                     i_ALU_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
    output logic [ADDRESS_WIDTH-1:0] o_IMEM_address,
    output logic [GHR_SIZE-1:0]      o_pred_pc,
    output logic                     o_fetch_valid,
    output logic                     o_isbranch_check,
    output logic [GHR_SIZE-1:0]      o_ALU_pc,
    output logic                     o_ALU_isbranch,
    output logic                     o_ALU_prediction,
    output logic                     o_redirect,
    output logic [CNT_WIDTH-1:0]     o_mispredict_count
);

    localparam int unsigned TAG_BITS    = ADDRESS_WIDTH - BTB_INDEX_BITS;
    localparam int unsigned BTB_ENTRIES = 1 << BTB_INDEX_BITS;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic                     valid;
        logic [ADDRESS_WIDTH-1:0] pc;
        logic                     hit;
        logic                     pred_taken;
        logic [ADDRESS_WIDTH-1:0] pred_target;
    } entry_t;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] pc, pc_next;
    entry_t                   fd, da, fetch_entry;

    logic [BTB_ENTRIES-1:0]   btb_valid;
    logic [TAG_BITS-1:0]      btb_tag    [BTB_ENTRIES];
    logic [ADDRESS_WIDTH-1:0] btb_target [BTB_ENTRIES];

    logic [BTB_INDEX_BITS-1:0] fetch_idx, da_idx;
    logic                      fetch_valid, btb_hit, isbranch_check, fetch_pred_taken;
    logic                      resolve, mispredict;
    logic [ADDRESS_WIDTH-1:0]  redirect_pc;
    logic [CNT_WIDTH-1:0]      mispredict_count;

    // BTB lookup on the fetch PC; hit/prediction only count for real fetches so
    // bubbles never carry a prediction down the pipe.
    assign fetch_idx        = pc[BTB_INDEX_BITS-1:0];
    assign fetch_valid      = (state == ST_RUN);
    assign btb_hit          = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == pc[ADDRESS_WIDTH-1:BTB_INDEX_BITS]);
    assign isbranch_check   = fetch_valid && btb_hit;
    assign fetch_pred_taken = isbranch_check && i_taken;

    assign fetch_entry = '{valid:       fetch_valid,
                           pc:          pc,
                           hit:         isbranch_check,
                           pred_taken:  fetch_pred_taken,
                           pred_target: btb_target[fetch_idx]};

    // A non-branch predicted taken is a BTB alias and must also redirect.
    assign da_idx      = da.pc[BTB_INDEX_BITS-1:0];
    assign resolve     = da.valid && !i_Stall;
    assign mispredict  = resolve &&
                         ((i_ALU_is_branch && (i_ALU_taken != da.pred_taken)) ||
                          (i_ALU_is_branch && i_ALU_taken && da.pred_taken &&
                           (i_ALU_target != da.pred_target)) ||
                          (!i_ALU_is_branch && da.pred_taken));
    assign redirect_pc = i_ALU_taken ? i_ALU_target : da.pc + ADDRESS_WIDTH'(1);

    // Next-state and next-PC; a redirect overrides stall and the FSM state.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (mispredict) begin
            state_next = ST_FLUSH;
            pc_next    = redirect_pc;
        end else begin
            case (state)
                ST_BOOT:  state_next = ST_RUN;
                ST_FLUSH: state_next = ST_RUN;
                ST_RUN: begin
                    if (!i_Stall) begin
                        pc_next = fetch_pred_taken ? btb_target[fetch_idx]
                                                   : pc + ADDRESS_WIDTH'(1);
                    end
                end
                default:  state_next = ST_BOOT;
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= ST_BOOT;
            pc    <= ADDRESS_WIDTH'(RESET_PC);
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // In-flight tracking; a flush only drops the valid bits.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            fd <= '0;
            da <= '0;
        end else if (mispredict) begin
            fd.valid <= 1'b0;
            da.valid <= 1'b0;
        end else if (!i_Stall) begin
            fd <= fetch_entry;
            da <= fd;
        end
    end

    // BTB valid bits: learn taken branches, forget aliases hit by non-branches.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            btb_valid <= '0;
        end else if (resolve) begin
            if (i_ALU_is_branch && i_ALU_taken) begin
                btb_valid[da_idx] <= 1'b1;
            end else if (!i_ALU_is_branch && da.hit) begin
                btb_valid[da_idx] <= 1'b0;
            end
        end
    end

    // BTB tag/target payload is qualified by the valid bit, so needs no reset.
    always_ff @(posedge i_Clk) begin
        if (resolve && i_ALU_is_branch && i_ALU_taken) begin
            btb_tag[da_idx]    <= da.pc[ADDRESS_WIDTH-1:BTB_INDEX_BITS];
            btb_target[da_idx] <= i_ALU_target;
        end
    end

    // Saturating misprediction counter.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            mispredict_count <= '0;
        end else if (mispredict && (mispredict_count != {CNT_WIDTH{1'b1}})) begin
            mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end

    assign o_IMEM_address     = pc;
    assign o_pred_pc          = pc[GHR_SIZE-1:0];
    assign o_fetch_valid      = fetch_valid;
    assign o_isbranch_check   = isbranch_check;
    assign o_ALU_pc           = da.pc[GHR_SIZE-1:0];
    assign o_ALU_isbranch     = da.hit;
    assign o_ALU_prediction   = da.pred_taken;
    assign o_redirect         = mispredict;
    assign o_mispredict_count = mispredict_count;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Testbench for fetch_predict_unit: directed scenarios plus randomized traffic,
// each cycle's expected outputs come from a behavioural model and are queued
// for an independent monitor that compares them at the falling clock edge.
// The counter is narrowed so that saturation is reachable in a short run.
module tb_fetch_predict_unit;

    localparam int AW      = 22;
    localparam int GHR     = 8;
    localparam int BI      = 4;
    localparam int CW      = 6;
    localparam int PC_MOD  = 1 << AW;
    localparam int BTB_N   = 1 << BI;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          i_Clk = 1'b0;
    logic          i_Reset;
    logic          i_Stall;
    logic          i_taken;
    logic          i_ALU_is_branch;
    logic          i_ALU_taken;
    logic [AW-1:0] i_ALU_target;
    logic [AW-1:0] o_IMEM_address;
    logic [GHR-1:0] o_pred_pc;
    logic          o_fetch_valid;
    logic          o_isbranch_check;
    logic [GHR-1:0] o_ALU_pc;
    logic          o_ALU_isbranch;
    logic          o_ALU_prediction;
    logic          o_redirect;
    logic [CW-1:0] o_mispredict_count;

    always #5 i_Clk = ~i_Clk;

    fetch_predict_unit #(
        .ADDRESS_WIDTH (AW),
        .GHR_SIZE      (GHR),
        .BTB_INDEX_BITS(BI),
        .RESET_PC      (0),
        .CNT_WIDTH     (CW)
    ) dut (
        .i_Clk             (i_Clk),
        .i_Reset           (i_Reset),
        .i_Stall           (i_Stall),
        .i_taken           (i_taken),
        .i_ALU_is_branch   (i_ALU_is_branch),
        .i_ALU_taken       (i_ALU_taken),
        .i_ALU_target      (i_ALU_target),
        .o_IMEM_address    (o_IMEM_address),
        .o_pred_pc         (o_pred_pc),
        .o_fetch_valid     (o_fetch_valid),
        .o_isbranch_check  (o_isbranch_check),
        .o_ALU_pc          (o_ALU_pc),
        .o_ALU_isbranch    (o_ALU_isbranch),
        .o_ALU_prediction  (o_ALU_prediction),
        .o_redirect        (o_redirect),
        .o_mispredict_count(o_mispredict_count)
    );

    typedef struct {
        int addr; int ppc; bit fv; bit chk;
        int apc; bit aisb; bit apred; bit redir; int cnt;
    } exp_t;

    typedef struct { bit valid; int pc; bit hit; bit pred; int target; } slot_t;
    typedef struct { bit valid; int tag; int target; } btb_t;

    exp_t  exp_q[$];
    slot_t pipe[2];          // [0] = decode slot, [1] = ALU slot
    btb_t  btb[BTB_N];
    int    m_pc, m_bubbles, m_miss;
    int    prog[int];        // pc -> taken target, -1 branch not taken, -2 non-branch
    bit    dir_taken;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic void modelReset();
        m_pc      = 0;
        m_bubbles = 1;
        m_miss    = 0;
        for (int i = 0; i < 2; i++) pipe[i] = '{valid: 0, pc: 0, hit: 0, pred: 0, target: 0};
        for (int i = 0; i < BTB_N; i++) btb[i].valid = 0;
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, advance the model.
    task automatic applyStimulus(input bit rst, input bit stall, input bit tk,
                                 input bit isb, input bit atk, input int tgt);
        exp_t  e;
        slot_t fe, da;
        bit    wrong;
        int    idx;
        i_Reset         = rst;
        i_Stall         = stall;
        i_taken         = tk;
        i_ALU_is_branch = isb;
        i_ALU_taken     = atk;
        i_ALU_target    = AW'(tgt);
        if (rst) modelReset();
        idx       = m_pc % BTB_N;
        fe.valid  = (m_bubbles == 0);
        fe.pc     = m_pc;
        fe.hit    = fe.valid && btb[idx].valid && (btb[idx].tag == m_pc / BTB_N);
        fe.pred   = fe.hit && tk;
        fe.target = btb[idx].target;
        da        = pipe[1];
        wrong     = da.valid && !stall &&
                    (isb ? ((atk != da.pred) || (atk && tgt != da.target)) : da.pred);
        e.addr  = m_pc;
        e.ppc   = m_pc % 256;
        e.fv    = fe.valid;
        e.chk   = fe.hit;
        e.apc   = da.pc % 256;
        e.aisb  = da.hit;
        e.apred = da.pred;
        e.redir = wrong;
        e.cnt   = (m_miss > CNT_MAX) ? CNT_MAX : m_miss;
        exp_q.push_back(e);
        if (!rst) begin
            if (da.valid && !stall) begin
                if (isb && atk) btb[da.pc % BTB_N] = '{valid: 1, tag: da.pc / BTB_N, target: tgt};
                else if (!isb && da.hit) btb[da.pc % BTB_N].valid = 0;
            end
            if (wrong) begin
                m_miss++;
                m_pc          = atk ? tgt : (da.pc + 1) % PC_MOD;
                m_bubbles     = 1;
                pipe[0].valid = 0;
                pipe[1].valid = 0;
            end else begin
                if (m_bubbles > 0) m_bubbles--;
                else if (!stall) m_pc = fe.pred ? fe.target : (m_pc + 1) % PC_MOD;
                if (!stall) begin
                    pipe[1] = pipe[0];
                    pipe[0] = fe;
                end
            end
        end
        @(posedge i_Clk);
        #1;
    endtask

    // Directed step: ALU outcome taken from the small program table.
    task automatic stepProg(input bit stall);
        bit isb = 0, atk = 0;
        int tgt = 0;
        if (pipe[1].valid && prog.exists(pipe[1].pc)) begin
            if (prog[pipe[1].pc] >= 0) begin isb = 1; atk = 1; tgt = prog[pipe[1].pc]; end
            else if (prog[pipe[1].pc] == -1) isb = 1;
        end
        applyStimulus(0, stall, dir_taken, isb, atk, tgt);
    endtask

    task automatic stepRandom(input bit allow_reset);
        bit isb, atk, rst, stall, tk;
        int tgt;
        rst   = allow_reset && ($urandom_range(0, 99) == 0);
        stall = ($urandom_range(0, 99) < 15);
        tk    = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) < 60) begin
            isb = pipe[1].pred ? 1'b1 : 1'($urandom_range(0, 1));
            atk = pipe[1].pred;
            tgt = pipe[1].pred ? pipe[1].target : 0;
        end else begin
            isb = 1'($urandom_range(0, 1));
            atk = isb && ($urandom_range(0, 1) == 1);
            tgt = ($urandom_range(0, 9) == 0) ? PC_MOD - 1 - int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 63));
        end
        applyStimulus(rst, stall, tk, isb, atk, tgt);
    endtask

    task automatic cmpField(input string name, input int act, input int req, inout bit bad);
        if (act != req) begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
            bad = 1;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        bit   bad = 0;
        e = exp_q.pop_front();
        vectors++;
        cmpField("imem_address",    int'(o_IMEM_address),     e.addr,  bad);
        cmpField("pred_pc",         int'(o_pred_pc),          e.ppc,   bad);
        cmpField("fetch_valid",     int'(o_fetch_valid),      e.fv,    bad);
        cmpField("isbranch_check",  int'(o_isbranch_check),   e.chk,   bad);
        cmpField("alu_pc",          int'(o_ALU_pc),           e.apc,   bad);
        cmpField("alu_isbranch",    int'(o_ALU_isbranch),     e.aisb,  bad);
        cmpField("alu_prediction",  int'(o_ALU_prediction),   e.apred, bad);
        cmpField("redirect",        int'(o_redirect),         e.redir, bad);
        cmpField("mispredict_count", int'(o_mispredict_count), e.cnt,  bad);
        if (bad) miscompares++;
    endtask

    // Monitor: independent of stimulus, compares once per cycle at negedge.
    initial begin
        forever begin
            @(negedge i_Clk);
            if (exp_q.size() > 0) checkOutput();
        end
    end

    task automatic timeoutFail(input string name);
        $display("[TB] FAIL %s: bound expired, got no match, expected a match", name);
        miscompares++;
    endtask

    initial begin
        int n;
        i_Reset = 1; i_Stall = 0; i_taken = 0;
        i_ALU_is_branch = 0; i_ALU_taken = 0; i_ALU_target = '0;
        modelReset();
        dir_taken = 0;
        @(posedge i_Clk);
        #1;

        $display("[TB] reset and sequential fetch, mid-run reset at PC 0x10");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        n = 0;
        while (m_pc != 16 && n < 40) begin stepProg(0); n++; end
        if (m_pc != 16) timeoutFail("reach_pc_0x10");
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (6) stepProg(0);

        $display("[TB] cold BTB learns branch 4->0x20 and loop back 0x22->4");
        applyStimulus(1, 0, 0, 0, 0, 0);
        prog[4] = 'h20; prog['h22] = 4; dir_taken = 1;
        repeat (30) stepProg(0);

        $display("[TB] BTB hit resolves not taken");
        prog[4] = -1;
        repeat (40) stepProg(0);

        $display("[TB] correct direction, wrong target 0x30");
        prog[4] = 'h30; prog['h32] = 4;
        repeat (30) stepProg(0);

        $display("[TB] non-branch aliasing a BTB entry");
        prog[4] = -2;
        repeat (40) stepProg(0);

        $display("[TB] stall holds state, pending mispredict waits for stall release");
        repeat (3) stepProg(1);
        prog[4] = 'h20;
        n = 0;
        while (!(pipe[1].valid && pipe[1].pc == 4) && n < 60) begin stepProg(0); n++; end
        if (!(pipe[1].valid && pipe[1].pc == 4)) timeoutFail("reach_alu_pc_4");
        repeat (3) stepProg(1);
        repeat (10) stepProg(0);

        $display("[TB] randomized traffic");
        applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (2500) stepRandom(0);
        repeat (1500) stepRandom(1);

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin @(negedge i_Clk); n++; end
        if (exp_q.size() > 0) timeoutFail("scoreboard_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
- Fetch-stage next-PC generator sitting directly upstream of the gshare branch_predictor. It drives the fetch address and hash bits into the predictor and consumes its combinational taken prediction.
- A direct-mapped branch target buffer (BTB) supplies taken-branch targets.
- Tracks in-flight predictions through decode to ALU, supplying the predictor's ALU-stage inputs.
- On ALU-stage misprediction, redirects fetch, flushes in-flight entries and updates the BTB.

Parameters:
- ADDRESS_WIDTH, 22, width of word-granular instruction address.
- GHR_SIZE, 8, width of the predictor hash/PC slice.
- BTB_INDEX_BITS, 4, log2 of BTB entries (16); tag = ADDRESS_WIDTH-BTB_INDEX_BITS bits.
- RESET_PC, 0, fetch address after reset.
- CNT_WIDTH, 16, width of the misprediction counter.

Ports:
- i_Clk  input  1  clock, all state on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Stall  input  1  pipeline stall; holds PC and in-flight registers.
- i_taken  input  1  predictor's prediction for the current fetch PC (combinational, same cycle).
- i_ALU_is_branch  input  1  instruction in ALU slot is actually a branch.
- i_ALU_taken  input  1  actual branch outcome.
- i_ALU_target  input  ADDRESS_WIDTH  actual taken target.
- o_IMEM_address  output  ADDRESS_WIDTH  current fetch PC.
- o_pred_pc  output  GHR_SIZE  o_IMEM_address[GHR_SIZE-1:0], to predictor i_IMEM_address.
- o_fetch_valid  output  1  fetch PC is a real instruction (not a bubble).
- o_isbranch_check  output  1  valid BTB hit on current PC while o_fetch_valid.
- o_ALU_pc  output  GHR_SIZE  low PC bits of ALU-slot entry.
- o_ALU_isbranch  output  1  ALU-slot entry was a BTB hit.
- o_ALU_prediction  output  1  prediction recorded for ALU-slot entry.
- o_redirect  output  1  misprediction detected this cycle (combinational).
- o_mispredict_count  output  CNT_WIDTH  saturating count of redirects.

Behaviour:
- Reset (async, any time, including mid-flush): PC=RESET_PC; all BTB valid bits=0; F/D and D/A valid=0; state=BOOT; counter=0. All outputs are then 0 except o_IMEM_address=RESET_PC and o_pred_pc=RESET_PC[GHR_SIZE-1:0].
- FSM states:
  - BOOT: o_fetch_valid=0, PC held; next state RUN unconditionally.
  - RUN: o_fetch_valid=1.
  - FLUSH: o_fetch_valid=0, PC holds redirect target; next state RUN.
- BTB lookup on PC: hit = valid[idx] && tag match.
  - pred_taken = hit && i_taken.
  - The target is used only when pred_taken.
- In-flight pipeline entry {valid, pc, hit, pred_taken, pred_target}.
  - When !i_Stall: F/D <= current fetch entry (valid=o_fetch_valid), D/A <= F/D.
  - When i_Stall: both are held.
- Resolution occurs when D/A.valid && !i_Stall. Mispredict if any of:
  - is_branch && taken != pred_taken;
  - is_branch && taken && pred_taken && target != pred_target;
  - !is_branch && pred_taken (alias).
- Next PC, highest priority first:
  1. reset;
  2. mispredict -> (taken ? i_ALU_target : D/A.pc+1), state FLUSH, F/D and D/A valid cleared;
  3. i_Stall or state != RUN -> hold;
  4. pred_taken -> BTB target;
  5. PC+1, wrapping modulo 2^ADDRESS_WIDTH.
- A redirect overrides i_Stall.
- BTB write at resolution:
  - is_branch && taken: write valid/tag/target.
  - !is_branch && hit: clear valid.
  - Otherwise no change.
  - A same-cycle lookup at the same index sees the old contents.
- Counter increments on each redirect and saturates at all-ones.
- A redirect occurring while in FLUSH is impossible, since the pipeline is empty. A redirect occurring in BOOT is likewise impossible.

Test Plan:
- Reset mid-run with PC=0x00010: o_IMEM_address=0 immediately; o_fetch_valid=0 for 1 cycle after release, then sequential 0,1,2,3.
- Cold BTB; branch at PC 4 resolves taken, target 0x20: o_redirect=1, PC=0x20 with 1 bubble, counter=1. Next visit to PC 4 with i_taken=1 fetches 0x20 next cycle with no redirect.
- BTB hit at 4, i_taken=1, resolves not-taken: redirect to 5; BTB entry stays valid; counter increments.
- BTB hit and correct direction but i_ALU_target=0x30 vs stored 0x20: redirect to 0x30; BTB target updated to 0x30.
- Non-branch aliasing a BTB entry, predicted taken: redirect to pc+1; entry invalidated; o_isbranch_check=0 on revisit.
- i_Stall held 3 cycles: PC, o_ALU_* and counter are unchanged. A mispredict asserted during stall is not resolved until stall drops; 2^CNT_WIDTH+5 forced mispredicts leave counter at 0xFFFF.
